// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : Oversampled UART transmitter. A payload is sent as a start bit,
//             DATA_WIDTH data bits LSB first, an optional even/odd parity bit
//             and a stop bit. Each bit lasts OVERSAMPLE clk_32 cycles.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int PAR_EN     = 1,
   parameter int PAR_TYPE   = 0,
   parameter int OVERSAMPLE = 32
) (
   input  logic                  clk_32,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   output logic                  tx_out,
   output logic                  busy
);

   // Counter widths: the bit-period counter is exactly ceil(log2(OVERSAMPLE))
   // bits; the bit index needs at least one bit even for a 1-bit payload.
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CW-1:0] c_CNT_MAX  = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
   localparam logic [IW-1:0] c_IDX_MAX  = IW'(DATA_WIDTH - 1);
   localparam logic [IW-1:0] c_IDX_ONE  = IW'(1);
   localparam logic          c_ODD      = (PAR_TYPE != 0);
   localparam logic          c_PAR_ON   = (PAR_EN != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                  state_q,  state_d;
   logic [CW-1:0]           cnt_q,    cnt_d;
   logic [IW-1:0]           idx_q,    idx_d;
   logic [DATA_WIDTH-1:0]   shift_q,  shift_d;
   logic                    par_q,    par_d;
   logic                    tx_q,     tx_d;
   logic                    busy_q,   busy_d;

   logic                    w_bit_end;
   logic [DATA_WIDTH-1:0]   w_shift_nxt;

   // Last cycle of the current bit period, and the payload after one shift.
   assign w_bit_end   = (cnt_q == c_CNT_MAX);
   assign w_shift_nxt = shift_q >> 1;

   // State and datapath registers; reset wins over any pending request.
   always_ff @(posedge clk_32) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic. tx_d/busy_d carry the level of the *next* cycle, so the
   // registered outputs change on the same edge as the state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;

      case (state_q)
         S_IDLE: begin
            cnt_d  = '0;
            idx_d  = '0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (data_valid) begin
               // Latch payload; parity of the latched word is fixed here so
               // later p_data changes cannot affect the frame.
               state_d = S_START;
               shift_d = p_data;
               par_d   = (^p_data) ^ c_ODD;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end

         S_START: begin
            if (w_bit_end) begin
               cnt_d   = '0;
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end else begin
               cnt_d   = cnt_q + c_CNT_ONE;
            end
         end

         S_DATA: begin
            if (w_bit_end) begin
               cnt_d   = '0;
               shift_d = w_shift_nxt;
               if (idx_q == c_IDX_MAX) begin
                  idx_d = '0;
                  if (c_PAR_ON) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + c_IDX_ONE;
                  tx_d  = w_shift_nxt[0];
               end
            end else begin
               cnt_d = cnt_q + c_CNT_ONE;
            end
         end

         S_PARITY: begin
            if (w_bit_end) begin
               cnt_d   = '0;
               state_d = S_STOP;
               tx_d    = 1'b1;
            end else begin
               cnt_d   = cnt_q + c_CNT_ONE;
            end
         end

         S_STOP: begin
            if (w_bit_end) begin
               // Always pass through IDLE for one cycle before a new frame.
               cnt_d   = '0;
               state_d = S_IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cnt_d   = cnt_q + c_CNT_ONE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign tx_out = tx_q;
   assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Directed self-checking bench for uart_tx. Three instances cover
//             even parity (default), odd parity and no parity.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

   localparam int OS = 32;

   logic       clk_32;
   logic       rst;
   logic [2:0] dv;
   logic [7:0] pd [3];
   logic [2:0] txw;
   logic [2:0] bsy;

   int   n_pass;
   int   n_total;
   logic exp_q [$];

   uart_tx #(.DATA_WIDTH(8), .PAR_EN(1), .PAR_TYPE(0), .OVERSAMPLE(OS)) u_even (
      .clk_32(clk_32), .rst(rst), .p_data(pd[0]), .data_valid(dv[0]),
      .tx_out(txw[0]), .busy(bsy[0]));

   uart_tx #(.DATA_WIDTH(8), .PAR_EN(1), .PAR_TYPE(1), .OVERSAMPLE(OS)) u_odd (
      .clk_32(clk_32), .rst(rst), .p_data(pd[1]), .data_valid(dv[1]),
      .tx_out(txw[1]), .busy(bsy[1]));

   uart_tx #(.DATA_WIDTH(8), .PAR_EN(0), .PAR_TYPE(0), .OVERSAMPLE(OS)) u_nopar (
      .clk_32(clk_32), .rst(rst), .p_data(pd[2]), .data_valid(dv[2]),
      .tx_out(txw[2]), .busy(bsy[2]));

   initial clk_32 = 1'b0;
   always #5 clk_32 = ~clk_32;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Expected line levels, one entry per bit period.
   function automatic void push_frame(input int d, input logic [7:0] data);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(data[i]);
      if (d != 2) exp_q.push_back((^data) ^ (d == 1));
      exp_q.push_back(1'b1);
   endfunction

   // Called at the negedge of the first frame cycle; consumes the scoreboard
   // cycle by cycle, then checks the single idle cycle that must follow.
   // When inj >= 0 a request for 8'h3C is pulsed on instance 0 at that cycle.
   task automatic check_frame(input int d, input int inj, input string tag);
      int   cyc;
      logic e;
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int k = 0; k < OS; k++) begin
            chk({tag, "_tx"},   txw[d], e);
            chk({tag, "_busy"}, bsy[d], 1'b1);
            if (inj >= 0 && cyc == inj) begin
               dv[0] = 1'b1;
               pd[0] = 8'h3C;
            end else if (inj >= 0 && cyc == inj + 1) begin
               dv[0] = 1'b0;
            end
            cyc++;
            @(negedge clk_32);
         end
      end
      chk({tag, "_end_tx"},   txw[d], 1'b1);
      chk({tag, "_end_busy"}, bsy[d], 1'b0);
   endtask

   // Single-cycle request; returns at the negedge of the first frame cycle.
   task automatic send(input int d, input logic [7:0] data);
      @(negedge clk_32);
      dv[d] = 1'b1;
      pd[d] = data;
      push_frame(d, data);
      @(negedge clk_32);
      dv[d] = 1'b0;
      pd[d] = ~data;
   endtask

   task automatic idle_check(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         for (int d = 0; d < 3; d++) begin
            chk({tag, "_tx"},   txw[d], 1'b1);
            chk({tag, "_busy"}, bsy[d], 1'b0);
         end
         @(negedge clk_32);
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      dv      = 3'b000;
      for (int d = 0; d < 3; d++) pd[d] = 8'h00;

      // Reset held two cycles, then idle until a request.
      @(negedge clk_32);
      idle_check(2, "reset");
      rst = 1'b0;
      idle_check(5, "post_reset");

      // Default frame, even parity.
      send(0, 8'hA5);
      check_frame(0, -1, "even_A5");

      // Odd parity and no-parity variants.
      send(1, 8'hA5);
      check_frame(1, -1, "odd_A5");
      send(2, 8'hA5);
      check_frame(2, -1, "nopar_A5");

      // Request at cycle 100 of a frame is ignored; nothing follows.
      send(0, 8'h5A);
      check_frame(0, 100, "ignored_req");
      idle_check(40, "no_second_frame");

      // Back-to-back with data_valid held high: 00 then FF.
      @(negedge clk_32);
      dv[0] = 1'b1;
      pd[0] = 8'h00;
      push_frame(0, 8'h00);
      @(negedge clk_32);
      pd[0] = 8'hFF;
      check_frame(0, -1, "b2b_00");
      push_frame(0, 8'hFF);
      @(negedge clk_32);
      dv[0] = 1'b0;
      check_frame(0, -1, "b2b_FF");
      @(negedge clk_32);
      idle_check(3, "after_b2b");

      // Mid-frame reset during a zero data bit.
      send(0, 8'h00);
      exp_q.delete();
      repeat (OS + 10) @(negedge clk_32);
      chk("pre_abort_tx", txw[0], 1'b0);
      rst = 1'b1;
      @(negedge clk_32);
      rst = 1'b0;
      chk("abort_tx",   txw[0], 1'b1);
      chk("abort_busy", bsy[0], 1'b0);
      idle_check(3, "after_abort");

      // Reset and request on the same edge: reset wins.
      dv[0] = 1'b1;
      pd[0] = 8'h81;
      rst   = 1'b1;
      @(negedge clk_32);
      rst   = 1'b0;
      dv[0] = 1'b0;
      chk("rst_prio_tx",   txw[0], 1'b1);
      chk("rst_prio_busy", bsy[0], 1'b0);
      idle_check(2, "after_rst_prio");

      // New request after the abort is accepted normally.
      send(0, 8'hA5);
      check_frame(0, -1, "after_abort_A5");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
